// File: rtl/bcd2_scan_display.sv
// Two-digit multiplexed 7-segment driver: snapshots a BCD pair once per scan frame
// and time-multiplexes it onto a shared segment bus with one-hot digit enables.

module bcd2_scan_display #(
    parameter int SCAN_DIV     = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int LZB          = 1,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in1,
    input  logic [3:0] in0,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic       frame
);

    localparam int MAX_A  = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int MAX_C  = (MAX_A > 2) ? MAX_A : 2;
    localparam int TW     = $clog2(MAX_C);

    localparam logic [TW-1:0] SHOW_TC = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] GAP_TC  = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : TW'(0);
    localparam logic [TW-1:0] RST_TC  = GAP_TC;

    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_OFF = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        ST_SHOW0 = 2'd0,
        ST_GAP0  = 2'd1,
        ST_SHOW1 = 2'd2,
        ST_GAP1  = 2'd3
    } state_t;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_snap1;
    logic [3:0]    r_snap0;
    logic [6:0]    r_seg;
    logic [1:0]    r_dig;
    logic          r_frame;

    state_t        w_state_next;
    logic [TW-1:0] w_timer_next;
    logic          w_tc;
    logic          w_enter_show0;
    logic [3:0]    w_snap1_next;
    logic [3:0]    w_snap0_next;
    logic [6:0]    w_seg_raw;
    logic [1:0]    w_dig_raw;
    logic [6:0]    w_seg_next;
    logic [1:0]    w_dig_next;

    // Phase sequencing: terminal-count detection, next state and timer reload.
    always_comb begin
        w_tc         = 1'b0;
        w_state_next = r_state;
        w_timer_next = r_timer + TW'(1);
        case (r_state)
            ST_SHOW0, ST_SHOW1: w_tc = (r_timer == SHOW_TC);
            ST_GAP0, ST_GAP1: begin
                // With no gap configured a GAP state is only reachable from reset.
                if (BLANK_CYCLES == 0) begin
                    w_tc = 1'b1;
                end else begin
                    w_tc = (r_timer == GAP_TC);
                end
            end
            default: w_tc = 1'b1;
        endcase
        if (w_tc) begin
            w_timer_next = TW'(0);
            case (r_state)
                ST_SHOW0: w_state_next = (BLANK_CYCLES > 0) ? ST_GAP0 : ST_SHOW1;
                ST_GAP0:  w_state_next = ST_SHOW1;
                ST_SHOW1: w_state_next = (BLANK_CYCLES > 0) ? ST_GAP1 : ST_SHOW0;
                ST_GAP1:  w_state_next = ST_SHOW0;
                default:  w_state_next = ST_SHOW0;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Next snapshot and next display values, derived from the state being entered.
    always_comb begin
        w_enter_show0 = w_tc && (w_state_next == ST_SHOW0);
        w_snap1_next  = r_snap1;
        w_snap0_next  = r_snap0;
        w_seg_raw     = 7'h00;
        w_dig_raw     = 2'b00;
        if (w_enter_show0) begin
            w_snap1_next = in1;
            w_snap0_next = in0;
        end else begin
            w_snap1_next = r_snap1;
            w_snap0_next = r_snap0;
        end
        case (w_state_next)
            ST_SHOW0: begin
                w_dig_raw = 2'b01;
                w_seg_raw = decode(w_snap0_next);
            end
            ST_SHOW1: begin
                w_dig_raw = 2'b10;
                if ((LZB != 0) && (w_snap1_next == 4'd0)) begin
                    w_seg_raw = 7'h00;
                end else begin
                    w_seg_raw = decode(w_snap1_next);
                end
            end
            default: begin
                w_dig_raw = 2'b00;
                w_seg_raw = 7'h00;
            end
        endcase
        if (ACTIVE_LOW != 0) begin
            w_seg_next = ~w_seg_raw;
            w_dig_next = ~w_dig_raw;
        end else begin
            w_seg_next = w_seg_raw;
            w_dig_next = w_dig_raw;
        end
    end

    // State, timer, snapshot and registered output update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_GAP1;
            r_timer <= RST_TC;
            r_snap1 <= 4'd0;
            r_snap0 <= 4'd0;
            r_seg   <= SEG_OFF;
            r_dig   <= DIG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_snap1 <= w_snap1_next;
            r_snap0 <= w_snap0_next;
            r_seg   <= w_seg_next;
            r_dig   <= w_dig_next;
            r_frame <= w_enter_show0;
        end
    end

    assign seg   = r_seg;
    assign dig   = r_dig;
    assign frame = r_frame;

    bcd2_scan_display_chk #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .dig   (dig),
        .seg   (seg),
        .frame (frame)
    );

endmodule

// Safety checks on the display outputs: digit enables never both on, and
// an unlit digit bus always comes with an all-off segment bus.
module bcd2_scan_display_chk #(
    parameter int ACTIVE_LOW = 0
) (
    input logic       clk,
    input logic       reset,
    input logic [1:0] dig,
    input logic [6:0] seg,
    input logic       frame
);

    logic [1:0] w_dig_ah;
    logic [6:0] w_seg_ah;

    assign w_dig_ah = (ACTIVE_LOW != 0) ? ~dig : dig;
    assign w_seg_ah = (ACTIVE_LOW != 0) ? ~seg : seg;

    a_dig_not_both: assert property (@(posedge clk) disable iff (reset)
        w_dig_ah != 2'b11);

    a_off_means_dark: assert property (@(posedge clk) disable iff (reset)
        (w_dig_ah == 2'b00) |-> (w_seg_ah == 7'h00));

    a_frame_on_units: assert property (@(posedge clk) disable iff (reset)
        frame |-> (w_dig_ah == 2'b01));

endmodule

// File: tb/tb_bcd2_scan_display.sv
// Scoreboard bench for bcd2_scan_display: three parameterisations share stimulus,
// a frame-position reference model predicts each cycle, a monitor compares.

module tb_bcd2_scan_display;

    typedef struct packed {
        logic       frame;
        logic [1:0] dig;
        logic [6:0] seg;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in1;
    logic [3:0] in0;

    logic [6:0] seg0, seg1, seg2;
    logic [1:0] dig0, dig1, dig2;
    logic       frame0, frame1, frame2;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance parameters: 0 = defaults, 1 = no blanking of tens, 2 = active-low fast scan.
    int p_s [3] = '{4, 3, 1};
    int p_b [3] = '{1, 2, 0};
    int p_l [3] = '{1, 0, 1};
    int p_a [3] = '{0, 0, 1};

    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    always #5 clk = ~clk;

    bcd2_scan_display u_dut0 (
        .clk(clk), .reset(reset), .in1(in1), .in0(in0),
        .seg(seg0), .dig(dig0), .frame(frame0)
    );

    bcd2_scan_display #(
        .SCAN_DIV(3), .BLANK_CYCLES(2), .LZB(0), .ACTIVE_LOW(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .in1(in1), .in0(in0),
        .seg(seg1), .dig(dig1), .frame(frame1)
    );

    bcd2_scan_display #(
        .SCAN_DIV(1), .BLANK_CYCLES(0), .LZB(1), .ACTIVE_LOW(1)
    ) u_dut2 (
        .clk(clk), .reset(reset), .in1(in1), .in0(in0),
        .seg(seg2), .dig(dig2), .frame(frame2)
    );

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 4'd9) return 7'h79;
        return tbl[d];
    endfunction

    // Display expected at position pos within a frame of 2*(S+B) cycles.
    function automatic obs_t ref_out(input int pos, input int s, input int b,
                                     input int lzb, input int al,
                                     input logic [3:0] s1, input logic [3:0] s0);
        obs_t o;
        o.frame = (pos == 0);
        o.dig   = 2'b00;
        o.seg   = 7'h00;
        if (pos < s) begin
            o.dig = 2'b01;
            o.seg = ref_dec(s0);
        end else if (pos < s + b) begin
            o.dig = 2'b00;
        end else if (pos < 2 * s + b) begin
            o.dig = 2'b10;
            o.seg = (lzb != 0 && s1 == 4'd0) ? 7'h00 : ref_dec(s1);
        end
        if (al != 0) begin
            o.dig = ~o.dig;
            o.seg = ~o.seg;
        end
        return o;
    endfunction

    function automatic obs_t off_val(input int i);
        obs_t o;
        o.frame = 1'b0;
        o.dig   = (p_a[i] != 0) ? 2'b11 : 2'b00;
        o.seg   = (p_a[i] != 0) ? 7'h7F : 7'h00;
        return o;
    endfunction

    function automatic obs_t act_val(input int i);
        case (i)
            0:       return {frame0, dig0, seg0};
            1:       return {frame1, dig1, seg1};
            default: return {frame2, dig2, seg2};
        endcase
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got frame=%0b dig=%b seg=%h, want frame=%0b dig=%b seg=%h",
                     name, $time, act.frame, act.dig, act.seg, exp.frame, exp.dig, exp.seg);
        end
    endtask

    // Reference model: counts edges since reset release, snapshots on frame start.
    initial begin
        int         k [3];
        logic [3:0] m1 [3];
        logic [3:0] m0 [3];
        obs_t       e;
        int         pos;
        for (int i = 0; i < 3; i++) begin
            k[i]  = 0;
            m1[i] = 4'd0;
            m0[i] = 4'd0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (reset) begin
                    k[i] = 0;
                end else begin
                    pos = k[i] % (2 * (p_s[i] + p_b[i]));
                    if (pos == 0) begin
                        m1[i] = in1;
                        m0[i] = in0;
                    end
                    e = ref_out(pos, p_s[i], p_b[i], p_l[i], p_a[i], m1[i], m0[i]);
                    case (i)
                        0:       q0.push_back(e);
                        1:       q1.push_back(e);
                        default: q2.push_back(e);
                    endcase
                    k[i] = k[i] + 1;
                end
            end
        end
    end

    // Monitor: compare every instance on the falling edge.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("reset_off_%0d", i), act_val(i), off_val(i));
                end
                q0.delete();
                q1.delete();
                q2.delete();
            end else begin
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("scan_0", act_val(0), e);
                end
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("scan_1", act_val(1), e);
                end
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    check("scan_2", act_val(2), e);
                end
            end
        end
    end

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (frame0) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL wait_frame: no frame pulse within 40 cycles, want one");
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus.
    initial begin
        int  cnt;
        bit  seen;
        reset = 1'b0;
        in1   = 4'd4;
        in0   = 4'd2;
        #1 reset = 1'b1;
        run(3);
        #1 reset = 1'b0;
        run(30);

        // Mid-frame input change must not tear the display.
        in1 = 4'd0;
        in0 = 4'd9;
        wait_frame();
        run(2);
        in1 = 4'd1;
        in0 = 4'd0;
        run(25);

        in1 = 4'd0;
        in0 = 4'd7;
        run(25);
        in1 = 4'd12;
        in0 = 4'd15;
        run(25);

        // Live counter 00..99..00 stepping every 10 cycles, off frame alignment.
        run(3);
        cnt = 0;
        for (int st = 0; st <= 100; st++) begin
            in1 = 4'(cnt / 10);
            in0 = 4'(cnt % 10);
            run(10);
            cnt = (cnt + 1) % 100;
        end

        repeat (200) begin
            in1 = 4'($urandom_range(15, 0));
            in0 = 4'($urandom_range(15, 0));
            run($urandom_range(3, 1));
        end

        // Reset asserted while the tens digit is lit.
        in1 = 4'd3;
        in0 = 4'd8;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (dig0 == 2'b10) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL wait_show1: tens digit not lit within 20 cycles, want dig=10");
        end
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_immediate_%0d", i), act_val(i), off_val(i));
        end
        run(3);
        #1 reset = 1'b0;
        in1 = 4'd5;
        in0 = 4'd6;
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
